vga_timing_gen: RTL and testbench

Parametrised VGA timing generator; successor to the fixed 640x480 driver. Adds configurable timing and widths, selectable sync polarity, a pixel clock-enable, frame/line strobes and a frame counter. Adds a fetch-ahead port that leads the display-side outputs by LOOKAHEAD pixels, hiding framebuffer read latency. Sits between the pixel clock domain and the framebuffer/renderer and the VGA DAC (blank_n, sync_n).

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_axis_counter.sv | 35 +++
 rtl/vga_timing_gen.sv | 181 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and colour-bar palette.
package vga_pkg;

  typedef struct packed {
    logic [15:0] display;
    logic [15:0] fp;
    logic [15:0] pulse;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    logic      h_pol;
    logic      v_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h: '{display: 16'd640, fp: 16'd16, pulse: 16'd96, bp: 16'd48},
    v: '{display: 16'd480, fp: 16'd10, pulse: 16'd2, bp: 16'd33},
    h_pol: 1'b0,
    v_pol: 1'b0
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h: '{display: 16'd800, fp: 16'd40, pulse: 16'd128, bp: 16'd88},
    v: '{display: 16'd600, fp: 16'd1, pulse: 16'd4, bp: 16'd23},
    h_pol: 1'b1,
    v_pol: 1'b1
  };

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic int unsigned total(vga_axis_t a);
    return 32'(a.display) + 32'(a.fp) + 32'(a.pulse) + 32'(a.bp);
  endfunction

  // Indices past the last bar (non-multiple-of-8 widths) stay black.
  function automatic logic [23:0] bar_colour(int unsigned idx);
    logic [23:0] c;
    case (idx)
      0:       c = COL_WHITE;
      1:       c = COL_YELLOW;
      2:       c = COL_CYAN;
      3:       c = COL_GREEN;
      4:       c = COL_MAGENTA;
      5:       c = COL_RED;
      6:       c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter with enable and terminal-count flag.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [CW-1:0] max_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == max_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with fetch-ahead port.
// Optional colour-bar output enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW         = 11,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_PULSE    = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_PULSE    = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  parameter int unsigned LOOKAHEAD  = 2,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  output logic [CW-1:0]      fetch_x,
  output logic [CW-1:0]      fetch_y,
  output logic               fetch_valid,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic               sync_n,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [23:0]        rgb
);

  localparam int unsigned H_TOTAL = total(vga_axis_t'{display: 16'(H_DISPLAY), fp: 16'(H_FP),
                                                      pulse: 16'(H_PULSE), bp: 16'(H_BP)});
  localparam int unsigned V_TOTAL = total(vga_axis_t'{display: 16'(V_DISPLAY), fp: 16'(V_FP),
                                                      pulse: 16'(V_PULSE), bp: 16'(V_BP)});

  if (LOOKAHEAD > 4 || H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : gen_bad_cfg
    $error("vga_timing_gen: LOOKAHEAD > 4 or totals do not fit CW");
  end

  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DISP_C = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_DISP_C = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FP + H_PULSE - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FP + V_PULSE - 1);
  localparam logic          HS_ACT   = (H_SYNC_POL != 0);
  localparam logic          VS_ACT   = (V_SYNC_POL != 0);

  // Sync flags are carried active-high; polarity is applied only at the pins.
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          vid;
    logic          hs;
    logic          vs;
    logic          eol;
    logic          eof;
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0]   rgb;
`endif
  } stage_t;

  logic [CW-1:0] h, v;
  logic          h_tc, v_tc;
  stage_t        fetch_st, disp_st;

  vga_axis_counter #(.CW(CW)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (pix_ce),
    .max_i (H_MAX),
    .cnt_o (h),
    .tc_o  (h_tc)
  );

  vga_axis_counter #(.CW(CW)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (pix_ce & h_tc),
    .max_i (V_MAX),
    .cnt_o (v),
    .tc_o  (v_tc)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_DISPLAY >= 8) ? H_DISPLAY / 8 : 1;
`endif

  always_comb begin
    fetch_st     = '0;
    fetch_st.x   = h;
    fetch_st.y   = v;
    fetch_st.vid = (h < H_DISP_C) && (v < V_DISP_C);
    fetch_st.hs  = (h >= HS_START) && (h <= HS_END);
    fetch_st.vs  = (v >= VS_START) && (v <= VS_END);
    fetch_st.eol = h_tc;
    fetch_st.eof = h_tc & v_tc;
`ifdef VGA_TEST_PATTERN_EN
    fetch_st.rgb = fetch_st.vid ? bar_colour(32'(h) / BAR_W) : 24'h000000;
`endif
  end

  if (LOOKAHEAD == 0) begin : gen_no_pipe
    assign disp_st = fetch_st;
  end else begin : gen_pipe
    // Reset flushes to position (0,0) with every flag clear, so nothing is shown early.
    stage_t pipe_q [LOOKAHEAD];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(LOOKAHEAD); i++) begin
          pipe_q[i] <= '0;
        end
      end else if (pix_ce) begin
        pipe_q[0] <= fetch_st;
        for (int i = 1; i < int'(LOOKAHEAD); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign disp_st = pipe_q[LOOKAHEAD-1];
  end

  // The stage leaving the output at line/frame end means x (or x,y) becomes 0 next.
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    line_start_d  = pix_ce & disp_st.eol;
    frame_start_d = pix_ce & disp_st.eof;
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign fetch_x     = h;
  assign fetch_y     = v;
  assign fetch_valid = fetch_st.vid;
  assign x           = disp_st.x;
  assign y           = disp_st.y;
  assign video_on    = disp_st.vid;
  assign blank_n     = disp_st.vid;
  assign hsync       = disp_st.hs ? HS_ACT : ~HS_ACT;
  assign vsync       = disp_st.vs ? VS_ACT : ~VS_ACT;
  assign sync_n      = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_TEST_PATTERN_EN
  assign rgb = disp_st.rgb;
`else
  assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a pixel-index reference model predicts every output each clock.
module tb_vga_timing_gen;

  localparam int CW = 6;
  localparam int HD = 8, HFP = 2, HP = 3, HBP = 3;
  localparam int VD = 4, VFP = 1, VP = 2, VBP = 1;
  localparam int HT = HD + HFP + HP + HBP;
  localparam int VT = VD + VFP + VP + VBP;
  localparam int FRAME = HT * VT;
  localparam int LA = 2;
  localparam int FW = 8;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  typedef struct packed {
    logic [5:0]  fx;
    logic [5:0]  fy;
    logic        fv;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic        ls;
    logic        fs;
    logic [7:0]  fcnt;
    logic [23:0] rgb;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_ce;
  logic [CW-1:0] fetch_x, fetch_y, x, y;
  logic          fetch_valid, video_on, hsync, vsync, blank_n, sync_n;
  logic          line_start, frame_start;
  logic [FW-1:0] frame_cnt;
  logic [23:0]   rgb;

  vga_timing_gen #(
    .CW(CW), .H_DISPLAY(HD), .H_FP(HFP), .H_PULSE(HP), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_PULSE(VP), .V_BP(VBP),
    .H_SYNC_POL(int'(HPOL)), .V_SYNC_POL(int'(VPOL)), .LOOKAHEAD(LA), .FRAME_W(FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .fetch_valid (fetch_valid),
    .x           (x),
    .y           (y),
    .video_on    (video_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .rgb         (rgb)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n = 0;
  bit   rst_cur, ce_cur;
  bit   counting = 1'b0;
  int   fs_seen = 0;
  bit   wrap_seen = 1'b0;
  logic [7:0] prev_fcnt = 8'd0;

  // n = pixel-clock-enables since reset; display shows pixel n-LA (flushed if negative).
  function automatic obs_t model(int pix, bit stb);
    obs_t e;
    int p, m, q, dx, dy;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    e = '0;
    p = pix % FRAME;
    e.fx = 6'(p % HT);
    e.fy = 6'(p / HT);
    e.fv = ((p % HT) < HD) && ((p / HT) < VD);
    m = pix - LA;
    if (m < 0) begin
      e.x = '0; e.y = '0; e.von = 1'b0;
      e.hs = ~HPOL; e.vs = ~VPOL;
    end else begin
      q = m % FRAME;
      dx = q % HT;
      dy = q / HT;
      e.x = 6'(dx);
      e.y = 6'(dy);
      e.von = (dx < HD) && (dy < VD);
      e.hs = (dx >= HD + HFP && dx <= HD + HFP + HP - 1) ? HPOL : ~HPOL;
      e.vs = (dy >= VD + VFP && dy <= VD + VFP + VP - 1) ? VPOL : ~VPOL;
`ifdef VGA_TEST_PATTERN_EN
      if (e.von) e.rgb = bars[dx / (HD / 8)];
`endif
    end
    e.bn = e.von;
    e.sn = 1'b0;
    e.ls = stb && m > 0 && (m % HT) == 0;
    e.fs = stb && m > 0 && (m % FRAME) == 0;
    e.fcnt = (m > 0) ? 8'((m / FRAME) % 256) : 8'd0;
    return e;
  endfunction

  task automatic cycle(input bit rst_v, input bit ce_v);
    bit stb;
    @(posedge clk);
    if (rst_cur) n = 0;
    else if (ce_cur) n = n + 1;
    stb = !rst_cur && ce_cur;
    #1;
    reset = rst_v;
    pix_ce = ce_v;
    rst_cur = rst_v;
    ce_cur = ce_v;
    if (rst_v) begin
      n = 0;
      stb = 1'b0;
    end
    exp_q.push_back(model(n, stb));
  endtask

  function automatic string show(obs_t o);
    return $sformatf("fx=%0d fy=%0d fv=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b bn=%0b sn=%0b ls=%0b fs=%0b fcnt=%0d rgb=%h",
                     o.fx, o.fy, o.fv, o.x, o.y, o.von, o.hs, o.vs, o.bn, o.sn, o.ls, o.fs,
                     o.fcnt, o.rgb);
  endfunction

  always @(negedge clk) begin
    obs_t e, a;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.fx = fetch_x; a.fy = fetch_y; a.fv = fetch_valid;
      a.x = x; a.y = y; a.von = video_on; a.hs = hsync; a.vs = vsync;
      a.bn = blank_n; a.sn = sync_n; a.ls = line_start; a.fs = frame_start;
      a.fcnt = frame_cnt; a.rgb = rgb;
      n_checks = n_checks + 1;
      if (a === e) n_pass = n_pass + 1;
      else $display("FAIL outputs cycle %0d: got %s | required %s", cyc, show(a), show(e));
    end
    if (counting) begin
      if (frame_start === 1'b1) fs_seen = fs_seen + 1;
      if (prev_fcnt == 8'd255 && frame_cnt == 8'd0) wrap_seen = 1'b1;
    end
    prev_fcnt = frame_cnt;
  end

  initial begin
    reset = 1'b1;
    pix_ce = 1'b0;
    rst_cur = 1'b1;
    ce_cur = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    repeat (2 * FRAME + 5) cycle(1'b0, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b0, (i % 2) == 0);
    repeat (3 * FRAME) cycle(1'b0, $urandom_range(0, 3) != 0);
    repeat ($urandom_range(20, 100)) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    counting = 1'b1;
    repeat (256 * FRAME + 66) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    counting = 1'b0;

    n_checks = n_checks + 1;
    if (fs_seen == 256) n_pass = n_pass + 1;
    else $display("FAIL frame_start_count: got %0d required 256", fs_seen);

    n_checks = n_checks + 1;
    if (wrap_seen) n_pass = n_pass + 1;
    else $display("FAIL frame_cnt_wrap: got no 255->0 step required one");

    n_checks = n_checks + 1;
    if (exp_q.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
